// File: rtl/dfd_dst_arb_mux.sv
// dfd_dst_arb_mux: registered, flow-controlled destination arbiter for the
// CLA debug-signal path. Picks one of LEVELS valid/ready sources (fixed
// priority or round-robin, with an optional burst lock) and presents the
// winning data through a one-deep output register.
module dfd_dst_arb_mux #(
  parameter int WIDTH   = 8,
  parameter int LEVELS  = 4,
  parameter int BURST_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mode_rr,
  input  logic [BURST_W-1:0] burst_len,
  input  logic [LEVELS-1:0]  req_valid,
  input  logic [WIDTH-1:0]   req_data [0:LEVELS-1],
  output logic [LEVELS-1:0]  req_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [LEVELS-1:0]  out_sel,
  input  logic               out_ready
);

  localparam int IDX_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [LEVELS-1:0]  out_sel_q, out_sel_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [IDX_W-1:0]   lock_idx_q, lock_idx_d;
  logic               lock_act_q, lock_act_d;
  logic [BURST_W-1:0] hold_cnt_q, hold_cnt_d;

  logic               load;
  logic               lock_hit;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic               xfer;
  logic [BURST_W:0]   hold_inc;
  int                 cand;

  // Winner selection: an honoured lock wins outright; otherwise fixed
  // priority takes the highest valid index, and round-robin searches
  // downward from last_grant-1 with wrap, visiting last_grant itself last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    lock_hit  = lock_act_q & req_valid[lock_idx_q];
    if (lock_hit) begin
      win_found = 1'b1;
      win_idx   = lock_idx_q;
    end else if (!mode_rr) begin
      for (int i = 0; i < LEVELS; i++) begin
        if (req_valid[i]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(i);
        end
      end
    end else begin
      for (int k = 1; k <= LEVELS; k++) begin
        cand = (int'(last_grant_q) + LEVELS - k) % LEVELS;
        if (!win_found && req_valid[cand]) begin
          win_found = 1'b1;
          win_idx   = IDX_W'(cand);
        end
      end
    end
  end

  // Handshake: the output register can take new data when empty or draining;
  // ready goes only to the winner and is suppressed during reset.
  always_comb begin
    load      = ~out_valid_q | out_ready;
    xfer      = load & win_found & ~reset;
    req_ready = xfer ? (LEVELS'(1) << win_idx) : '0;
  end

  // Next-state: load the winner, or empty the register when nothing wins;
  // maintain the burst lock (continue a streak or start a new grant).
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_sel_d    = out_sel_q;
    last_grant_d = last_grant_q;
    lock_idx_d   = lock_idx_q;
    lock_act_d   = lock_act_q;
    hold_cnt_d   = hold_cnt_q;
    hold_inc     = {1'b0, hold_cnt_q} + 1'b1;
    if (load) begin
      if (win_found) begin
        out_valid_d  = 1'b1;
        out_data_d   = req_data[win_idx];
        out_sel_d    = LEVELS'(1) << win_idx;
        last_grant_d = win_idx;
        if (lock_hit) begin
          hold_cnt_d = (hold_cnt_q == '1) ? hold_cnt_q : hold_inc[BURST_W-1:0];
          lock_act_d = (hold_inc < {1'b0, burst_len});
        end else begin
          lock_idx_d = win_idx;
          hold_cnt_d = '0;
          lock_act_d = (burst_len != '0);
        end
      end else begin
        out_valid_d = 1'b0;
        lock_act_d  = 1'b0;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_sel_q    <= '0;
      last_grant_q <= '0;
      lock_idx_q   <= '0;
      lock_act_q   <= 1'b0;
      hold_cnt_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_sel_q    <= out_sel_d;
      last_grant_q <= last_grant_d;
      lock_idx_q   <= lock_idx_d;
      lock_act_q   <= lock_act_d;
      hold_cnt_q   <= hold_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_dfd_dst_arb_mux.sv
// Testbench for dfd_dst_arb_mux: directed scenarios plus random traffic,
// checked against a streak-counting reference model of the arbiter.
module tb_dfd_dst_arb_mux;

  localparam int WIDTH   = 8;
  localparam int LEVELS  = 4;
  localparam int BURST_W = 4;

  logic               clk;
  logic               reset;
  logic               mode_rr;
  logic [BURST_W-1:0] burst_len;
  logic [LEVELS-1:0]  req_valid;
  logic [WIDTH-1:0]   req_data [0:LEVELS-1];
  logic [LEVELS-1:0]  req_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [LEVELS-1:0]  out_sel;
  logic               out_ready;

  int assert_count = 0;
  int fail_count   = 0;

  // Reference model state: what the output register should hold, who was
  // granted last, and the current streak of back-to-back grants.
  bit               m_out_valid = 0;
  logic [WIDTH-1:0] m_out_data  = '0;
  logic [LEVELS-1:0] m_out_sel  = '0;
  int               m_last      = 0;
  bit               m_locked    = 0;
  int               m_lock_src  = 0;
  int               m_streak    = 0;

  dfd_dst_arb_mux #(.WIDTH(WIDTH), .LEVELS(LEVELS), .BURST_W(BURST_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .mode_rr   (mode_rr),
    .burst_len (burst_len),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Winner by the rules: honoured lock first; fixed = highest valid index;
  // round-robin = valid index closest below the last grant, cyclically.
  function automatic int pickWinner(input logic [LEVELS-1:0] v, input bit rr);
    int best;
    int bestd;
    int d;
    if (m_locked && v[m_lock_src]) return m_lock_src;
    best  = -1;
    bestd = LEVELS;
    for (int i = 0; i < LEVELS; i++) begin
      if (v[i]) begin
        if (!rr) begin
          best = i;
        end else begin
          d = (m_last - i - 1 + 2 * LEVELS) % LEVELS;
          if (d < bestd) begin
            bestd = d;
            best  = i;
          end
        end
      end
    end
    return best;
  endfunction

  // One cycle: drive inputs at the falling edge, check the DUT against the
  // model, then advance the model to what the rising edge should produce.
  task automatic applyStimulus(input bit rst, input bit rr, input int bl,
                               input logic [LEVELS-1:0] v, input bit ordy);
    bit load;
    int w;
    logic [LEVELS-1:0] exp_ready;
    @(negedge clk);
    reset     = rst;
    mode_rr   = rr;
    burst_len = BURST_W'(bl);
    req_valid = v;
    out_ready = ordy;
    for (int i = 0; i < LEVELS; i++) req_data[i] = WIDTH'($urandom);
    #1;
    load = !m_out_valid || ordy;
    w    = pickWinner(v, rr);
    exp_ready = (!rst && load && w >= 0) ? (LEVELS'(1) << w) : '0;
    checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
    checkOutput("out_valid", 32'(out_valid), 32'(m_out_valid));
    checkOutput("out_data",  32'(out_data),  32'(m_out_data));
    checkOutput("out_sel",   32'(out_sel),   32'(m_out_sel));
    if (rst) begin
      m_out_valid = 0;
      m_out_data  = '0;
      m_out_sel   = '0;
      m_last      = 0;
      m_locked    = 0;
      m_lock_src  = 0;
      m_streak    = 0;
    end else if (load) begin
      if (w >= 0) begin
        if (m_locked && w == m_lock_src) begin
          m_streak++;
        end else begin
          m_streak   = 1;
          m_lock_src = w;
        end
        m_locked    = (m_streak <= bl);
        m_out_valid = 1;
        m_out_data  = req_data[w];
        m_out_sel   = LEVELS'(1) << w;
        m_last      = w;
      end else begin
        m_out_valid = 0;
        m_locked    = 0;
      end
    end
  endtask

  logic [LEVELS-1:0] rr_order [0:4];
  logic [LEVELS-1:0] burst_order [0:6];
  int rbl;
  bit rrr;

  initial begin
    rr_order    = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    burst_order = '{4'b1000, 4'b1000, 4'b1000, 4'b0100, 4'b0100, 4'b0100, 4'b0010};
    reset = 1'b1; mode_rr = 1'b0; burst_len = '0; req_valid = '0; out_ready = 1'b0;
    for (int i = 0; i < LEVELS; i++) req_data[i] = '0;
    repeat (2) @(posedge clk);

    $display("[TB] fixed priority, valid 1011");
    applyStimulus(1, 0, 0, 4'b0000, 1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, 0, 0, 4'b1011, 1);
      checkOutput("fixed_ready", 32'(req_ready), 32'(4'b1000));
    end
    applyStimulus(0, 0, 0, 4'b0000, 1);
    checkOutput("fixed_sel", 32'(out_sel), 32'(4'b1000));

    $display("[TB] round-robin order");
    applyStimulus(1, 1, 0, 4'b0000, 1);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 4'b1111, 1);
      checkOutput("rr_order", 32'(req_ready), 32'(rr_order[k]));
    end

    $display("[TB] round-robin with burst 2");
    applyStimulus(1, 1, 0, 4'b0000, 1);
    for (int k = 0; k < 7; k++) begin
      applyStimulus(0, 1, 2, 4'b1111, 1);
      checkOutput("burst_order", 32'(req_ready), 32'(burst_order[k]));
    end

    $display("[TB] reset mid-burst and stall");
    applyStimulus(0, 1, 2, 4'b1111, 0);
    applyStimulus(1, 1, 2, 4'b1111, 0);
    applyStimulus(0, 1, 0, 4'b1111, 1);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sel", 32'(out_sel), 32'd0);
    checkOutput("rst_first_rr", 32'(req_ready), 32'(4'b1000));

    $display("[TB] backpressure");
    for (int k = 0; k < 5; k++) begin
      applyStimulus(0, 1, 0, 4'b1111, 0);
      checkOutput("stall_ready", 32'(req_ready), 32'd0);
    end
    applyStimulus(0, 1, 0, 4'b1111, 1);
    checkOutput("stall_release", 32'(req_ready), 32'(4'b0100));

    $display("[TB] lock break in fixed mode");
    applyStimulus(0, 0, 3, 4'b0100, 1);
    applyStimulus(0, 0, 3, 4'b1100, 1);
    checkOutput("lock_hold", 32'(req_ready), 32'(4'b0100));
    applyStimulus(0, 0, 3, 4'b1011, 1);
    checkOutput("lock_break", 32'(req_ready), 32'(4'b1000));
    applyStimulus(0, 0, 3, 4'b1111, 1);
    checkOutput("lock_moved", 32'(req_ready), 32'(4'b1000));

    $display("[TB] random traffic");
    rbl = 1;
    rrr = 1;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 19) == 0) rbl = $urandom_range(0, 5);
      if ($urandom_range(0, 29) == 0) rrr = ~rrr;
      applyStimulus($urandom_range(0, 49) == 0, rrr, rbl,
                    LEVELS'($urandom), $urandom_range(0, 9) < 7);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule
